uart_tx_framed: RTL and testbench

UART_TX_FRAMED -- requirements
Module: uart_tx_framed

---
 rtl/uart_tx_framed.sv | 194 +++++++++++++++++++
 tb/tb_uart_tx_framed.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framed.sv
// Framed UART transmitter: START, DATA_BITS data bits (LSB first), optional parity, STOP_BITS stop bits.
// Latency: the start bit appears on o_Tx_Serial one clock after acceptance; every bit lasts N = max(i_Clks_Per_Bit, 2) clocks.
// Backpressure: o_Tx_Ready is low for the whole frame; i_Tx_DV is ignored while it is low, and requests are not queued.
//
// Ports:
//   i_Clock, i_Rst_L       rising-edge clock, synchronous active-low reset
//   i_Tx_DV, i_Tx_Data     frame request and payload, sampled only when o_Tx_Ready=1
//   i_Clks_Per_Bit         bit period in clocks, latched per frame (values below 2 become 2)
//   i_Parity_En/Odd        parity insert / odd select, present only with UART_TX_PARITY_EN defined
//   o_Tx_Ready             idle and out of reset
//   o_Tx_Active            frame on the line
//   o_Tx_Serial            registered serial line, idles high
//   o_Tx_Done              one-cycle pulse in the first idle cycle after a completed frame
// Optional feature macro: UART_TX_PARITY_EN (adds the parity ports and the PARITY state).

module uart_tx_framed #(
    parameter int CPB_W     = 16,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_L,
    input  logic                 i_Tx_DV,
    input  logic [DATA_BITS-1:0] i_Tx_Data,
    input  logic [CPB_W-1:0]     i_Clks_Per_Bit,
`ifdef UART_TX_PARITY_EN
    input  logic                 i_Parity_En,
    input  logic                 i_Parity_Odd,
`endif
    output logic                 o_Tx_Ready,
    output logic                 o_Tx_Active,
    output logic                 o_Tx_Serial,
    output logic                 o_Tx_Done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        , S_PARITY = 3'd4
`endif
    } state_t;

    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic [CPB_W-1:0] MIN_DIV   = CPB_W'(2);

    state_t                 state_q, state_n;
    logic [CPB_W-1:0]       cnt_q, cnt_n;      // clocks elapsed within the current bit
    logic [3:0]             bit_q, bit_n;      // data-bit index, then stop-bit index
    logic [DATA_BITS-1:0]   shift_q, shift_n;  // remaining payload, next bit in [0]
    logic [CPB_W-1:0]       div_q, div_n;      // latched, clamped bit period
    logic                   serial_q, serial_n;
    logic                   active_q, active_n;
    logic                   done_q, done_n;
    logic                   bit_end;
`ifdef UART_TX_PARITY_EN
    logic                   par_q, par_n;      // parity bit value computed at acceptance
    logic                   pen_q, pen_n;      // parity bit is part of this frame
`endif

    assign bit_end     = (cnt_q == (div_q - CPB_W'(1)));
    assign o_Tx_Ready  = (state_q == S_IDLE) && i_Rst_L;
    assign o_Tx_Active = active_q;
    assign o_Tx_Serial = serial_q;
    assign o_Tx_Done   = done_q;

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            div_q    <= MIN_DIV;
            serial_q <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
            pen_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            bit_q    <= bit_n;
            shift_q  <= shift_n;
            div_q    <= div_n;
            serial_q <= serial_n;
            active_q <= active_n;
            done_q   <= done_n;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_n;
            pen_q    <= pen_n;
`endif
        end
    end

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        bit_n    = bit_q;
        shift_n  = shift_q;
        div_n    = div_q;
        serial_n = serial_q;
        done_n   = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n    = par_q;
        pen_n    = pen_q;
`endif
        // Every non-idle state spends exactly div_q clocks per bit.
        if (state_q != S_IDLE) begin
            cnt_n = bit_end ? '0 : cnt_q + CPB_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                serial_n = 1'b1;
                if (i_Tx_DV) begin
                    state_n  = S_START;
                    cnt_n    = '0;
                    bit_n    = '0;
                    shift_n  = i_Tx_Data;
                    div_n    = (i_Clks_Per_Bit < MIN_DIV) ? MIN_DIV : i_Clks_Per_Bit;
                    serial_n = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_n    = (^i_Tx_Data) ^ i_Parity_Odd;
                    pen_n    = i_Parity_En;
`endif
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_n  = S_DATA;
                    bit_n    = '0;
                    serial_n = shift_q[0];
                    shift_n  = shift_q >> 1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == LAST_DATA) begin
                        bit_n    = '0;
                        state_n  = S_STOP;
                        serial_n = 1'b1;
`ifdef UART_TX_PARITY_EN
                        if (pen_q) begin
                            state_n  = S_PARITY;
                            serial_n = par_q;
                        end
`endif
                    end else begin
                        bit_n    = bit_q + 4'd1;
                        serial_n = shift_q[0];
                        shift_n  = shift_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_n  = S_STOP;
                    bit_n    = '0;
                    serial_n = 1'b1;
                end
            end
`endif
            S_STOP: begin
                serial_n = 1'b1;
                if (bit_end) begin
                    if (bit_q == LAST_STOP) begin
                        state_n = S_IDLE;
                        bit_n   = '0;
                        done_n  = 1'b1;
                    end else begin
                        bit_n = bit_q + 4'd1;
                    end
                end
            end
            default: begin
                // Unused encodings recover to idle with the line released.
                state_n  = S_IDLE;
                cnt_n    = '0;
                bit_n    = '0;
                serial_n = 1'b1;
            end
        endcase

        // Active tracks the registered state, so it covers start through last stop cycle.
        active_n = (state_n != S_IDLE);
    end

endmodule

// File: tb/tb_uart_tx_framed.sv
module tb_uart_tx_framed;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_l, dv0, dv1;
    logic [7:0]  data0;
    logic [6:0]  data1;
    logic [15:0] cpb0, cpb1;
`ifdef UART_TX_PARITY_EN
    logic        par_en, par_odd;
`endif
    logic [1:0]  rdy, act, ser, don;

    // Instance 0: 8 data bits, 1 stop bit.  Instance 1: 7 data bits, 2 stop bits.
    uart_tx_framed #(.CPB_W(16), .DATA_BITS(8), .STOP_BITS(1)) dut0 (
        .i_Clock        (clk),
        .i_Rst_L        (rst_l),
        .i_Tx_DV        (dv0),
        .i_Tx_Data      (data0),
        .i_Clks_Per_Bit (cpb0),
`ifdef UART_TX_PARITY_EN
        .i_Parity_En    (par_en),
        .i_Parity_Odd   (par_odd),
`endif
        .o_Tx_Ready     (rdy[0]),
        .o_Tx_Active    (act[0]),
        .o_Tx_Serial    (ser[0]),
        .o_Tx_Done      (don[0])
    );

    uart_tx_framed #(.CPB_W(16), .DATA_BITS(7), .STOP_BITS(2)) dut1 (
        .i_Clock        (clk),
        .i_Rst_L        (rst_l),
        .i_Tx_DV        (dv1),
        .i_Tx_Data      (data1),
        .i_Clks_Per_Bit (cpb1),
`ifdef UART_TX_PARITY_EN
        .i_Parity_En    (1'b0),
        .i_Parity_Odd   (1'b0),
`endif
        .o_Tx_Ready     (rdy[1]),
        .o_Tx_Active    (act[1]),
        .o_Tx_Serial    (ser[1]),
        .o_Tx_Done      (don[1])
    );

    // Model: each accepted frame is expanded into its list of per-clock line levels.
    bit  lvl [2][1024];
    int  len [2];
    int  pos [2];
    bit  pend [2];
    bit  e_ser [2];
    bit  e_act [2];
    bit  e_done [2];
    bit  started;

    int  checks, errors, cyc;
    int  act_total [2];
    int  done_total [2];
    int  done_cyc [2];
    int  prev_done_cyc [2];
    bit  cap [2][16384];

    task automatic push(input int k, input bit v, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            if (len[k] < 1024) lvl[k][len[k]] = v;
            len[k]++;
        end
    endtask

    task automatic model_step(input int k, input bit dv, input logic [8:0] d, input int n_raw,
                              input bit pe, input bit po, input int db, input int sb);
        int n;
        bit p;
        if (!rst_l) begin
            pos[k] = 0; len[k] = 0; pend[k] = 0;
            e_ser[k] = 1'b1; e_act[k] = 1'b0; e_done[k] = 1'b0;
            started = 1'b1;
        end else if (pos[k] < len[k]) begin
            e_ser[k] = lvl[k][pos[k]];
            pos[k]++;
            e_act[k] = 1'b1; e_done[k] = 1'b0;
            if (pos[k] == len[k]) pend[k] = 1'b1;
        end else if (pend[k]) begin
            pend[k] = 1'b0;
            e_ser[k] = 1'b1; e_act[k] = 1'b0; e_done[k] = 1'b1;
        end else if (dv) begin
            n = (n_raw < 2) ? 2 : n_raw;
            len[k] = 0;
            p = po;
            push(k, 1'b0, n);
            for (int i = 0; i < db; i++) begin
                push(k, d[i], n);
                p ^= d[i];
            end
            if (pe) push(k, p, n);
            push(k, 1'b1, n * sb);
            e_ser[k] = lvl[k][0];
            pos[k] = 1;
            e_act[k] = 1'b1; e_done[k] = 1'b0;
        end else begin
            e_ser[k] = 1'b1; e_act[k] = 1'b0; e_done[k] = 1'b0;
        end
    endtask

    task automatic cmp(input string name, input int k, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d] cycle %0d: got %b expected %b", name, k, cyc, got, exp);
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send0(input logic [7:0] d, input logic [15:0] n);
        dv0 = 1'b1; data0 = d; cpb0 = n;
        tick();
        dv0 = 1'b0;
    endtask

    task automatic send1(input logic [6:0] d, input logic [15:0] n);
        dv1 = 1'b1; data1 = d; cpb1 = n;
        tick();
        dv1 = 1'b0;
    endtask

    task automatic wait_done(input int k, input int base, input int budget, input string name);
        int i;
        i = 0;
        while (done_total[k] <= base && i < budget) begin
            tick();
            i++;
        end
        chk(name, (done_total[k] > base) ? 1 : 0, 1);
    endtask

    task automatic wait_idle(input int k, input int budget);
        int i;
        i = 0;
        while (!(rdy[k] === 1'b1 && act[k] === 1'b0) && i < budget) begin
            tick();
            i++;
        end
        chk("idle_reached", (rdy[k] === 1'b1) ? 1 : 0, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int b, d0;
        logic [9:0] pat;
        rst_l = 1'b0; dv0 = 1'b0; dv1 = 1'b0;
        data0 = '0; data1 = '0; cpb0 = 16'd4; cpb1 = 16'd3;
`ifdef UART_TX_PARITY_EN
        par_en = 1'b0; par_odd = 1'b0;
`endif
        fork
            forever begin
                @(posedge clk);
`ifdef UART_TX_PARITY_EN
                model_step(0, dv0, {1'b0, data0}, int'(cpb0), par_en, par_odd, 8, 1);
`else
                model_step(0, dv0, {1'b0, data0}, int'(cpb0), 1'b0, 1'b0, 8, 1);
`endif
                model_step(1, dv1, {2'b00, data1}, int'(cpb1), 1'b0, 1'b0, 7, 2);
            end
            forever begin
                @(negedge clk);
                cyc++;
                for (int k = 0; k < 2; k++) begin
                    if (started) begin
                        cmp("serial", k, ser[k], e_ser[k]);
                        cmp("active", k, act[k], e_act[k]);
                        cmp("done",   k, don[k], e_done[k]);
                        cmp("ready",  k, rdy[k], rst_l && (pos[k] == len[k]) && !pend[k]);
                    end
                    if (act[k] === 1'b1) begin
                        cap[k][act_total[k] & 16383] = ser[k];
                        act_total[k]++;
                    end
                    if (don[k] === 1'b1) begin
                        done_total[k]++;
                        prev_done_cyc[k] = done_cyc[k];
                        done_cyc[k] = cyc;
                    end
                end
            end
        join_none

        // Reset state
        tick(); tick(); #1;
        chk("rst_ready",  rdy[0], 0);
        chk("rst_serial", ser[0], 1);
        chk("rst_active", act[0], 0);
        chk("rst_done",   don[0], 0);
        rst_l = 1'b1; #1;
        chk("ready_after_rst", rdy[0], 1);

        // 8N1, N=4, 0xA5
        b = act_total[0]; d0 = done_total[0];
        send0(8'hA5, 16'd4);
        wait_done(0, d0, 200, "a5_done_seen");
        tick(); tick();
        chk("a5_len", act_total[0] - b, 40);
        chk("a5_done_count", done_total[0] - d0, 1);
        pat = 10'b1101001010;
        for (int i = 0; i < 10; i++) chk("a5_bit", cap[0][(b + i * 4 + 2) & 16383], pat[i]);

`ifdef UART_TX_PARITY_EN
        // Even then odd parity on 0xA5 (four ones)
        par_en = 1'b1; par_odd = 1'b0;
        b = act_total[0]; d0 = done_total[0];
        send0(8'hA5, 16'd4);
        wait_done(0, d0, 200, "par_even_done_seen");
        tick();
        chk("par_even_len", act_total[0] - b, 44);
        chk("par_even_bit", cap[0][(b + 9 * 4 + 2) & 16383], 0);
        chk("par_even_stop", cap[0][(b + 10 * 4 + 2) & 16383], 1);
        par_odd = 1'b1;
        b = act_total[0]; d0 = done_total[0];
        send0(8'hA5, 16'd4);
        par_odd = 1'b0;
        wait_done(0, d0, 200, "par_odd_done_seen");
        tick();
        chk("par_odd_len", act_total[0] - b, 44);
        chk("par_odd_bit", cap[0][(b + 9 * 4 + 2) & 16383], 1);
        par_en = 1'b0;
`endif

        // 7 data bits, 2 stop bits, N=3, 0x7F
        b = act_total[1]; d0 = done_total[1];
        send1(7'h7F, 16'd3);
        wait_done(1, d0, 200, "x7f_done_seen");
        tick();
        chk("x7f_len", act_total[1] - b, 30);
        chk("x7f_done_count", done_total[1] - d0, 1);
        pat = 10'b1111111110;
        for (int i = 0; i < 10; i++) chk("x7f_bit", cap[1][(b + i * 3 + 1) & 16383], pat[i]);

        // Back-to-back frames with i_Tx_DV held high, N=2
        d0 = done_total[0];
        dv0 = 1'b1; data0 = 8'h3C; cpb0 = 16'd2;
        wait_done(0, d0, 100, "b2b_done1");
        wait_done(0, d0 + 1, 100, "b2b_done2");
        chk("b2b_period_a", done_cyc[0] - prev_done_cyc[0], 21);
        wait_done(0, d0 + 2, 100, "b2b_done3");
        chk("b2b_period_b", done_cyc[0] - prev_done_cyc[0], 21);
        dv0 = 1'b0;
        wait_idle(0, 100);
        tick();

        // Divisor 0 clamps to 2; divisor and data changed mid-frame have no effect
        b = act_total[0]; d0 = done_total[0];
        send0(8'h3C, 16'd0);
        tick(); tick(); tick();
        cpb0 = 16'd7; data0 = 8'hFF;
        wait_done(0, d0, 200, "clamp_done_seen");
        tick();
        chk("clamp_len", act_total[0] - b, 20);
        pat = 10'b1001111000;
        for (int i = 0; i < 10; i++) chk("clamp_bit", cap[0][(b + i * 2 + 1) & 16383], pat[i]);
        cpb0 = 16'd4;

        // One-cycle reset in the middle of the data bits
        d0 = done_total[0];
        send0(8'hA5, 16'd4);
        for (int i = 0; i < 8; i++) tick();
        chk("mid_active_before_rst", act[0], 1);
        rst_l = 1'b0; #1;
        chk("mid_rst_ready", rdy[0], 0);
        tick();
        rst_l = 1'b1;
        chk("mid_rst_serial", ser[0], 1);
        chk("mid_rst_active", act[0], 0);
        chk("mid_rst_done",   don[0], 0);
        for (int i = 0; i < 10; i++) tick();
        chk("abort_no_done", done_total[0] - d0, 0);
        b = act_total[0]; d0 = done_total[0];
        send0(8'h5A, 16'd4);
        wait_done(0, d0, 200, "post_rst_done_seen");
        tick(); tick();
        chk("post_rst_len", act_total[0] - b, 40);
        chk("post_rst_done_count", done_total[0] - d0, 1);

        for (int i = 0; i < 5; i++) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
